// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-host bundle for uart_rx_fifo: byte strobe and data in, pop request, status out.
// UART_RX_FIFO_LEVEL_EN adds the occupancy count signal to both modports.
interface uart_rx_fifo_if #(
    parameter int B = 8,
    parameter int W = 4
);
    logic         rx_done_tick;
    logic [B-1:0] din;
    logic         rd_uart;
    logic         clr_overrun;
    logic [B-1:0] r_data;
    logic         rx_empty;
    logic         rx_full;
    logic         overrun;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [W:0]   level;

    modport master (
        output rx_done_tick, din, rd_uart, clr_overrun,
        input  r_data, rx_empty, rx_full, overrun, level
    );
    modport slave (
        input  rx_done_tick, din, rd_uart, clr_overrun,
        output r_data, rx_empty, rx_full, overrun, level
    );
`else
    modport master (
        output rx_done_tick, din, rd_uart, clr_overrun,
        input  r_data, rx_empty, rx_full, overrun
    );
    modport slave (
        input  rx_done_tick, din, rd_uart, clr_overrun,
        output r_data, rx_empty, rx_full, overrun
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead 2^W-entry receive FIFO with registered empty/full flags and a sticky overrun flag.
// Optional registered occupancy counter on the level signal when UART_RX_FIFO_LEVEL_EN is defined.
module uart_rx_fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << W;
    localparam logic [W-1:0] PTR_ONE = W'(1);

    logic [B-1:0] mem_q [DEPTH];
    logic [W-1:0] w_ptr_q, w_ptr_d;
    logic [W-1:0] r_ptr_q, r_ptr_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         overrun_q, overrun_d;
    logic         push, pop, drop;

    always_comb begin
        pop       = bus.rd_uart & ~empty_q;
        // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
        push      = bus.rx_done_tick & (~full_q | pop);
        drop      = bus.rx_done_tick & full_q & ~pop;
        w_ptr_d   = w_ptr_q;
        r_ptr_d   = r_ptr_q;
        empty_d   = empty_q;
        full_d    = full_q;
        if (push) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end
        if (pop) begin
            r_ptr_d = r_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            empty_d = 1'b0;
            full_d  = (w_ptr_d == r_ptr_q);
        end else if (pop && !push) begin
            full_d  = 1'b0;
            empty_d = (r_ptr_d == w_ptr_q);
        end
        // A drop in the same cycle as a clear wins.
        overrun_d = drop | (overrun_q & ~bus.clr_overrun);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[w_ptr_q] <= bus.din;
        end
    end

    assign bus.r_data   = empty_q ? '0 : mem_q[r_ptr_q];
    assign bus.rx_empty = empty_q;
    assign bus.rx_full  = full_q;
    assign bus.overrun  = overrun_q;

`ifdef UART_RX_FIFO_LEVEL_EN
    localparam logic [W:0] LVL_ONE = (W + 1)'(1);
    logic [W:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign bus.level = level_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios then randomized traffic against a queue model.
module tb_uart_rx_fifo;
    localparam int B = 8;
    localparam int W = 2;
    localparam int DEPTH = 1 << W;

    typedef struct {
        bit e;
        bit f;
        bit o;
        int lvl;
        int data;
    } stat_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    uart_rx_fifo_if #(.B(B), .W(W)) bus ();
    uart_rx_fifo #(.B(B), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [B-1:0] mq[$];
    bit           m_ovr = 1'b0;
    bit           model_ok = 1'b0;
    stat_t        stat_q[$];
    int           rd_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; queues what the outputs must show this cycle, then advances the model.
    task automatic step(input logic tick, input logic [B-1:0] d, input logic rd,
                        input logic clr, input logic rst);
        stat_t s;
        bit    do_pop, do_push;
        bus.rx_done_tick = tick;
        bus.din          = d;
        bus.rd_uart      = rd;
        bus.clr_overrun  = clr;
        reset            = rst;
        if (model_ok) begin
            s.e    = (mq.size() == 0);
            s.f    = (mq.size() == DEPTH);
            s.o    = m_ovr;
            s.lvl  = mq.size();
            s.data = (mq.size() > 0) ? int'(mq[0]) : 0;
            stat_q.push_back(s);
            if (rd && !rst && mq.size() > 0) rd_q.push_back(int'(mq[0]));
        end
        if (rst) begin
            mq.delete();
            m_ovr    = 1'b0;
            model_ok = 1'b1;
        end else begin
            do_pop  = rd && (mq.size() > 0);
            do_push = tick && (mq.size() < DEPTH || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(d);
            if (tick && !do_push) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        stat_t s;
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            check("rx_empty", int'(bus.rx_empty), int'(s.e));
            check("rx_full", int'(bus.rx_full), int'(s.f));
            check("overrun", int'(bus.overrun), int'(s.o));
            check("r_data", int'(bus.r_data), s.data);
`ifdef UART_RX_FIFO_LEVEL_EN
            check("level", int'(bus.level), s.lvl);
`endif
        end
        if (model_ok && bus.rd_uart && !bus.rx_empty && !reset) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_data", int'(bus.r_data), rd_q.pop_front());
        end
    end

    initial begin
        bus.rx_done_tick = 1'b0;
        bus.din          = '0;
        bus.rd_uart      = 1'b0;
        bus.clr_overrun  = 1'b0;
        reset            = 1'b1;
        @(posedge clk);
        #1;
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        // Three pushes, then three pops plus one ignored pop.
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        // Fill, drop one, clear racing a drop, then clear.
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0);
        step(1, 8'hA4, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'hA5, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        // Full with simultaneous push and pop.
        step(1, 8'hB4, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
        // Empty with simultaneous push and pop.
        step(1, 8'h5A, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // Pointer wrap, then reset while holding two entries.
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'h10 + 8'(i), 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h77, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // Randomized traffic with varying pop pressure.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 150; i++) begin
                step(logic'($urandom_range(0, 99) < 60),
                     B'($urandom),
                     logic'($urandom_range(0, 99) < 15 + 25 * p),
                     logic'($urandom_range(0, 7) == 0),
                     logic'($urandom_range(0, 99) == 0));
            end
        end
        step(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        check("rd_drain", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle `rx_done_tick` strobe and holds bytes in a 2^W-entry circular FIFO until the host logic pops them with `rd_uart`. It also reports empty and full status and a sticky overrun flag for bytes lost while the FIFO was full.

## Interface
Parameters:
- `B`, 8: data width in bits; matches the receiver's `dout`.
- `W`, 4: address width; FIFO depth is 2^W (16 entries by default).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset; sampled on rising `clk`.
- `rx_done_tick`  in  1  write strobe from the receiver, one cycle per received byte.
- `din`  in  B  received byte, valid in the cycle `rx_done_tick`=1.
- `rd_uart`  in  1  pop request from host logic.
- `r_data`  out  B  head-of-FIFO byte (show-ahead).
- `rx_empty`  out  1  FIFO holds 0 entries.
- `rx_full`  out  1  FIFO holds 2^W entries.
- `overrun`  out  1  sticky: at least one byte was dropped because the FIFO was full.
- `clr_overrun`  in  1  clears `overrun`.
- `level`  out  W+1  entry count, 0..2^W; present only with `UART_RX_FIFO_LEVEL_EN`.

## Operation
- Storage: 2^W × B register array. The array is not reset.
- Write pointer `w_ptr` and read pointer `r_ptr` are W bits wide and wrap modulo 2^W with no special case at 2^W-1 → 0.
- `rx_full` and `rx_empty` are registered flags, updated on the same edge as the pointers.
- Push condition: `rx_done_tick` & (~`rx_full` | pop). On push, `din` is written to `mem[w_ptr]` and `w_ptr` increments.
- Pop condition: `rd_uart` & ~`rx_empty`. On pop, `r_ptr` increments. `rd_uart` while empty is ignored, with no state change.
- Per-cycle cases for (push request, pop request):
  - Neither: hold.
  - Write only: push; `rx_empty`←0; `rx_full`←1 if the next `w_ptr` equals `r_ptr`.
  - Read only: pop; `rx_full`←0; `rx_empty`←1 if the next `r_ptr` equals `w_ptr`.
  - Both, FIFO neither empty nor full: push and pop; flags unchanged.
  - Both, FIFO empty: push only; read ignored; `rx_empty`←0.
  - Both, FIFO full: push and pop both proceed; stays full; no overrun.
- Overrun:
  - `rx_done_tick` & `rx_full` & ~pop: byte dropped, `overrun`←1, pointers and memory unchanged.
  - `overrun` holds until a cycle with `clr_overrun`=1 and no new drop.
  - Set has priority over clear in the same cycle.
- `r_data` = `rx_empty` ? 0 : `mem[r_ptr]` (combinational read of registered state).
- Reset (any time, including mid-burst): `w_ptr`=`r_ptr`=0, `rx_empty`=1, `rx_full`=0, `overrun`=0, `level`=0. Stored contents are discarded logically. Reset has priority over every other input.

## Timing
- Reset values: `r_data`=0, `rx_empty`=1, `rx_full`=0, `overrun`=0, `level`=0.
- Write latency: `rx_done_tick` sampled at edge N → `rx_empty`=0 and `r_data`=`din` immediately after edge N, i.e. visible in cycle N+1.
- Read: `r_data` is valid whenever `rx_empty`=0. The consumer samples `r_data` in the same cycle it asserts `rd_uart`. After edge N, `r_data` shows the next entry, or 0 if the FIFO is now empty.
- Flags and `level` change only on clock edges and are glitch-free relative to `clk`.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- `UART_RX_FIFO_LEVEL_EN` defined:
  - Adds the `level` output port and a W+1-bit registered occupancy counter.
  - Counter behaviour: +1 on push-only, −1 on pop-only, unchanged on push+pop, dropped writes, or ignored reads.
  - Counter range is 0..2^W; it equals 2^W exactly when `rx_full`=1.
- Not defined: no `level` port and no counter. All other behaviour is identical.

## Test plan
Directed scenarios, run with W=2 (depth 4), B=8:
- Reset, then 3 pushes 0x11, 0x22, 0x33 → `rx_empty` falls the cycle after the first tick; `r_data`=0x11; `level`=3.
- Pop 3 times with `rd_uart` → `r_data` sequence 0x11, 0x22, 0x33, then 0; `rx_empty`=1 after the third pop; a fourth `rd_uart` changes nothing.
- Push 0xA0..0xA3 → `rx_full`=1; push 0xA4 → `overrun`=1, 0xA4 is lost, and pops return 0xA0..0xA3; `overrun` stays 1 until `clr_overrun`; `clr_overrun` together with a drop in the same cycle leaves `overrun`=1.
- Full FIFO with `rx_done_tick`+`rd_uart` on the same cycle (din=0xB4) → pop returns 0xA0; stays full; `overrun` stays 0; the final pop order ends with 0xB4.
- Empty FIFO with simultaneous push 0x5A and `rd_uart` → read ignored; `r_data`=0x5A next cycle; `level`=1.
- 10 push/pop pairs (pointer wrap) then `reset` asserted with 2 entries held → next cycle all outputs at reset values; a subsequent push 0x77 gives `r_data`=0x77.
